// File: rtl/hiscore_ram_port.sv
// Hiscore RAM responder: pauses the CPU at a clean bus boundary, lends the
// work-RAM port to the hiscore engine, and hands it back glitch-free.
module hiscore_ram_port #(
  parameter logic [15:0] RAM_BASE  = 16'hC000,
  parameter int          RAM_AW    = 12,
  parameter int          DRAIN_CEN = 2
) (
  input  logic              clk48M,
  input  logic              reset,
  input  logic              hs_req,
  input  logic [15:0]       HSAD,
  input  logic [7:0]        HSDI,
  input  logic              HSWE,
  output logic [7:0]        HSDO,
  output logic              hs_grant,
  output logic              pause_req,
  input  logic              cpu_cen,
  input  logic [15:0]       cpu_ad,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_do,
  output logic [RAM_AW-1:0] ram_ad,
  output logic              ram_we,
  output logic [7:0]        ram_di,
  input  logic [7:0]        ram_do
);

  localparam int              CW      = (DRAIN_CEN < 1) ? 1 : $clog2(DRAIN_CEN + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DRAIN_CEN);
  localparam logic [16:0]     WIN_LO  = {1'b0, RAM_BASE};
  localparam logic [16:0]     WIN_HI  = WIN_LO + (17'd1 << RAM_AW);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    GRANT,
    RELEASE
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   drain_cnt, drain_cnt_nx;
  logic            hs_grant_nx, pause_req_nx;
  logic            in_win, in_win_d;
  logic            cpu_ad_unused;

  // Compare in 17 bits so a window ending at 16'hFFFF never wraps to zero.
  assign in_win        = ({1'b0, HSAD} >= WIN_LO) && ({1'b0, HSAD} < WIN_HI);
  assign cpu_ad_unused = ^cpu_ad[15:RAM_AW];

  always_comb begin
    state_nx     = state;
    drain_cnt_nx = '0;
    case (state)
      IDLE: begin
        if (hs_req) begin
          state_nx     = DRAIN;
          drain_cnt_nx = cpu_cen ? CW'(1) : '0;
        end
      end
      DRAIN: begin
        drain_cnt_nx = drain_cnt;
        if (cpu_cen && (drain_cnt < CNT_MAX))
          drain_cnt_nx = drain_cnt + CW'(1);
        if (!hs_req) begin
          state_nx     = IDLE;
          drain_cnt_nx = '0;
        end else if ((drain_cnt == CNT_MAX) && !cpu_cen) begin
          state_nx = GRANT;
        end
      end
      GRANT: begin
        if (!hs_req)
          state_nx = RELEASE;
      end
      RELEASE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    hs_grant_nx  = (state_nx == GRANT);
    pause_req_nx = (state_nx != IDLE);
  end

  // Grant and pause are flops so the RAM mux select never glitches.
  always_ff @(posedge clk48M or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      drain_cnt <= '0;
      hs_grant  <= 1'b0;
      pause_req <= 1'b0;
      in_win_d  <= 1'b0;
      HSDO      <= 8'h00;
    end else begin
      state     <= state_nx;
      drain_cnt <= drain_cnt_nx;
      hs_grant  <= hs_grant_nx;
      pause_req <= pause_req_nx;
      in_win_d  <= in_win;
      if (hs_grant)
        HSDO <= in_win_d ? ram_do : 8'h00;
    end
  end

  always_comb begin
    if (hs_grant) begin
      ram_ad = HSAD[RAM_AW-1:0] - RAM_BASE[RAM_AW-1:0];
      ram_we = HSWE & in_win;
      ram_di = HSDI;
    end else begin
      ram_ad = cpu_ad[RAM_AW-1:0];
      ram_we = cpu_we;
      ram_di = cpu_do;
    end
    if (reset)
      ram_we = 1'b0;
  end

endmodule

// File: tb/tb_hiscore_ram_port.sv
// Bench for hiscore_ram_port: directed stimulus pushes expected values into a
// scoreboard queue; a negedge monitor compares them when their cycle comes up.
module tb_hiscore_ram_port;

  logic        clk48M = 1'b0;
  logic        reset;
  logic        hs_req;
  logic [15:0] HSAD;
  logic [7:0]  HSDI;
  logic        HSWE;
  logic [7:0]  HSDO;
  logic        hs_grant;
  logic        pause_req;
  logic        cpu_cen;
  logic [15:0] cpu_ad;
  logic        cpu_we;
  logic [7:0]  cpu_do;
  logic [11:0] ram_ad;
  logic        ram_we;
  logic [7:0]  ram_di;
  logic [7:0]  ram_do;

  logic [7:0]  mem [0:4095];

  localparam int SIG_HSDO = 0, SIG_GRANT = 1, SIG_PAUSE = 2, SIG_WE = 3,
                 SIG_AD = 4, SIG_DI = 5, SIG_RDO = 6;

  typedef struct {
    int          cyc;
    int          sig;
    logic [15:0] exp;
    string       name;
  } expect_t;

  expect_t     exp_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;
  int          missed = 0;
  logic [15:0] act;

  hiscore_ram_port dut (
    .clk48M   (clk48M),
    .reset    (reset),
    .hs_req   (hs_req),
    .HSAD     (HSAD),
    .HSDI     (HSDI),
    .HSWE     (HSWE),
    .HSDO     (HSDO),
    .hs_grant (hs_grant),
    .pause_req(pause_req),
    .cpu_cen  (cpu_cen),
    .cpu_ad   (cpu_ad),
    .cpu_we   (cpu_we),
    .cpu_do   (cpu_do),
    .ram_ad   (ram_ad),
    .ram_we   (ram_we),
    .ram_di   (ram_di),
    .ram_do   (ram_do)
  );

  always #5 clk48M = ~clk48M;

  always @(posedge clk48M) cyc <= cyc + 1;

  // Write-first synchronous work RAM.
  always @(posedge clk48M) begin
    if (ram_we) begin
      mem[ram_ad] <= ram_di;
      ram_do      <= ram_di;
    end else begin
      ram_do <= mem[ram_ad];
    end
  end

  function automatic logic [15:0] getActual(input int sig);
    case (sig)
      SIG_HSDO:  return {8'h00, HSDO};
      SIG_GRANT: return {15'h0, hs_grant};
      SIG_PAUSE: return {15'h0, pause_req};
      SIG_WE:    return {15'h0, ram_we};
      SIG_AD:    return {4'h0, ram_ad};
      SIG_DI:    return {8'h00, ram_di};
      default:   return {8'h00, ram_do};
    endcase
  endfunction

  always @(negedge clk48M) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        act    = getActual(exp_q[i].sig);
        checks = checks + 1;
        if (act === exp_q[i].exp)
          passes = passes + 1;
        else
          $display("[TB] FAIL %s @cycle %0d: got %h, expected %h",
                   exp_q[i].name, cyc, act, exp_q[i].exp);
        exp_q.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk48M);
    #1;
  endtask

  // Advance one cycle, then drive the engine-side inputs for that cycle.
  task automatic applyStimulus(input logic req, input logic cen,
                               input logic [15:0] ad, input logic [7:0] di,
                               input logic we);
    tick();
    hs_req  = req;
    cpu_cen = cen;
    HSAD    = ad;
    HSDI    = di;
    HSWE    = we;
  endtask

  task automatic checkOutput(input string name, input int sig,
                             input logic [15:0] exp, input int dly);
    expect_t e;
    e.cyc  = cyc + dly;
    e.sig  = sig;
    e.exp  = exp;
    e.name = name;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected run to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; hs_req = 1'b0; HSAD = 16'h0; HSDI = 8'h0; HSWE = 1'b0;
    cpu_cen = 1'b0; cpu_ad = 16'h0; cpu_we = 1'b0; cpu_do = 8'h0;
    repeat (3) tick();
    reset = 1'b0;
    checkOutput("rst_grant", SIG_GRANT, 16'h0, 0);
    checkOutput("rst_pause", SIG_PAUSE, 16'h0, 0);
    checkOutput("rst_hsdo",  SIG_HSDO,  16'h0, 0);
    checks = checks + 1;
    if (hs_grant === 1'b0)
      passes = passes + 1;
    else
      $display("[TB] FAIL direct_rst_grant: got %b, expected 0", hs_grant);
    checks = checks + 1;
    if (pause_req === 1'b0)
      passes = passes + 1;
    else
      $display("[TB] FAIL direct_rst_pause: got %b, expected 0", pause_req);
    checks = checks + 1;
    if (HSDO === 8'h00)
      passes = passes + 1;
    else
      $display("[TB] FAIL direct_rst_hsdo: got %h, expected 00", HSDO);

    // CPU preloads RAM[0x010] through the idle mux
    applyStimulus(1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
    cpu_we = 1'b1; cpu_ad = 16'hC010; cpu_do = 8'h77;
    checkOutput("cpu_we_path", SIG_WE, 16'h1,   0);
    checkOutput("cpu_ad_path", SIG_AD, 16'h010, 0);
    applyStimulus(1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
    cpu_we = 1'b0; cpu_ad = 16'h0000;

    // Grant sequence: cpu_cen every 4 clk starting the cycle after hs_req
    applyStimulus(1'b1, 1'b0, 16'h0, 8'h0, 1'b0);
    checkOutput("pause_rise",      SIG_PAUSE, 16'h0, 0);
    checkOutput("pause_next_clk",  SIG_PAUSE, 16'h1, 1);
    checkOutput("no_grant_early",  SIG_GRANT, 16'h0, 1);
    checkOutput("no_grant_1pulse", SIG_GRANT, 16'h0, 6);
    checkOutput("grant_2pulses",   SIG_GRANT, 16'h1, 7);
    checkOutput("cpu_held_grant",  SIG_PAUSE, 16'h1, 9);
    for (int i = 1; i <= 9; i++)
      applyStimulus(1'b1, (i % 4) == 1, 16'h0, 8'h0, 1'b0);

    // Write path then read-after-write
    applyStimulus(1'b1, 1'b0, 16'hC123, 8'h5A, 1'b1);
    checkOutput("wr_we",     SIG_WE, 16'h1,   0);
    checkOutput("wr_ad",     SIG_AD, 16'h123, 0);
    checkOutput("wr_di",     SIG_DI, 16'h5A,  0);
    checkOutput("wr_we_one", SIG_WE, 16'h0,   1);
    checkOutput("raw_hsdo",  SIG_HSDO, 16'h5A, 3);
    applyStimulus(1'b1, 1'b0, 16'hC123, 8'h00, 1'b0);

    // Read latency, window edges, and HSDO tracking every cycle
    applyStimulus(1'b1, 1'b0, 16'hC010, 8'h00, 1'b0);
    checkOutput("rd_lat",       SIG_HSDO, 16'h77, 2);
    checkOutput("below_win_we", SIG_WE,   16'h0,  1);
    checkOutput("below_win_rd", SIG_HSDO, 16'h00, 3);
    checkOutput("rd_again",     SIG_HSDO, 16'h77, 4);
    checkOutput("above_win_we", SIG_WE,   16'h0,  3);
    checkOutput("above_win_rd", SIG_HSDO, 16'h00, 5);
    checkOutput("top_win_we",   SIG_WE,   16'h1,  4);
    checkOutput("top_win_ad",   SIG_AD,   16'hFFF, 4);
    checkOutput("top_win_rd",   SIG_HSDO, 16'hA5, 7);
    applyStimulus(1'b1, 1'b0, 16'hB000, 8'hEE, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'hC010, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'hD000, 8'hEE, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'hCFFF, 8'hA5, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'hCFFF, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'hC010, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'hC010, 8'h00, 1'b0);

    // Release: mux returns first, pause drops one clk later
    applyStimulus(1'b0, 1'b0, 16'hC010, 8'h00, 1'b0);
    cpu_ad = 16'hC123;
    checkOutput("rel_ad_engine", SIG_AD,    16'h010, 0);
    checkOutput("rel_grant_off", SIG_GRANT, 16'h0,   1);
    checkOutput("rel_ad_cpu",    SIG_AD,    16'h123, 1);
    checkOutput("rel_pause_on",  SIG_PAUSE, 16'h1,   1);
    checkOutput("rel_pause_off", SIG_PAUSE, 16'h0,   2);
    checkOutput("cpu_read_back", SIG_RDO,   16'h5A,  2);
    checkOutput("hsdo_hold",     SIG_HSDO,  16'h77,  4);
    repeat (3) applyStimulus(1'b0, 1'b0, 16'hC010, 8'h00, 1'b0);

    // One-clk request withdrawn during DRAIN
    applyStimulus(1'b1, 1'b1, 16'hC010, 8'h00, 1'b0);
    checkOutput("wd_pause_on",  SIG_PAUSE, 16'h1, 1);
    checkOutput("wd_pause_off", SIG_PAUSE, 16'h0, 2);
    checkOutput("wd_no_grant1", SIG_GRANT, 16'h0, 2);
    checkOutput("wd_no_grant2", SIG_GRANT, 16'h0, 3);
    applyStimulus(1'b0, 1'b1, 16'hC010, 8'h00, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 16'hC010, 8'h00, 1'b0);

    // Regain grant, then reset mid-write
    applyStimulus(1'b1, 1'b0, 16'hC010, 8'h00, 1'b0);
    checkOutput("re_no_grant", SIG_GRANT, 16'h0, 3);
    checkOutput("re_grant",    SIG_GRANT, 16'h1, 4);
    checkOutput("re_wr_we",    SIG_WE,    16'h1, 4);
    applyStimulus(1'b1, 1'b1, 16'hC010, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'hC010, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'hC010, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'hC200, 8'h33, 1'b1);
    tick();
    reset  = 1'b1;
    hs_req = 1'b0;
    checkOutput("rst_mid_we",    SIG_WE,    16'h0, 0);
    checkOutput("rst_mid_grant", SIG_GRANT, 16'h0, 0);
    checkOutput("rst_mid_pause", SIG_PAUSE, 16'h0, 0);
    checkOutput("rst_mid_hsdo",  SIG_HSDO,  16'h0, 0);
    tick();
    checks = checks + 1;
    if (ram_we === 1'b0)
      passes = passes + 1;
    else
      $display("[TB] FAIL direct_rst_mid_we: got %b, expected 0", ram_we);
    checks = checks + 1;
    if ((hs_grant === 1'b0) && (pause_req === 1'b0) && (HSDO === 8'h00))
      passes = passes + 1;
    else
      $display("[TB] FAIL direct_rst_mid_outs: got grant=%b pause=%b hsdo=%h, expected 0 0 00",
               hs_grant, pause_req, HSDO);
    tick();
    reset = 1'b0;
    HSWE  = 1'b0;
    checkOutput("post_rst_pause", SIG_PAUSE, 16'h0, 1);
    checkOutput("post_rst_grant", SIG_GRANT, 16'h0, 1);

    repeat (10) tick();
    missed = exp_q.size();
    for (int i = 0; i < missed; i++)
      $display("[TB] FAIL %s: got no sample, expected check at cycle %0d",
               exp_q[i].name, exp_q[i].cyc);
    if (missed != 0)
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", missed);
    if (passes != checks)
      $display("[TB] FAIL summary: got %0d passes, expected %0d", passes, checks);
    $display("%0d/%0d checks passed", passes, checks + missed);
    $finish;
  end

endmodule
